// File: rtl/dsp_bb_pkg.sv
// rtl/dsp_bb_pkg.sv - shared width helpers for the DSP building blocks
package dsp_bb_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Two guard bits keep the sign-extended sum exact for any operand pair.
   function automatic int sum_width(input int aw, input int bw);
      return max(aw, bw) + 2;
   endfunction

   function automatic int chan_width(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the search pointer
module rr_arbiter
   import dsp_bb_pkg::*;
#(
   parameter int N = 4,
   localparam int CW = chan_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          enable,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [CW-1:0] index
);

   logic [CW-1:0] ptr;
   logic          found;
   int            sel;

   // Search starts at the pointer and wraps, so the last winner goes to the back.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      sel   = 0;
      for (int i = 0; i < N; i++) begin
         sel = int'(ptr) + i;
         if (sel >= N) sel = sel - N;
         if (enable && !found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            index      = CW'(sel);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (index == CW'(N-1)) ? '0 : index + CW'(1);
      end
   end

endmodule

// File: rtl/signed_adder.sv
// rtl/signed_adder.sv - combinational exact-width signed adder
module signed_adder
   import dsp_bb_pkg::*;
#(
   parameter int AWIDTH = 16,
   parameter int BWIDTH = 16,
   localparam int SWIDTH = sum_width(AWIDTH, BWIDTH)
) (
   input  logic signed [AWIDTH-1:0] a,
   input  logic signed [BWIDTH-1:0] b,
   output logic signed [SWIDTH-1:0] sum
);

   logic signed [SWIDTH-1:0] a_ext;
   logic signed [SWIDTH-1:0] b_ext;

   assign a_ext = {{(SWIDTH-AWIDTH){a[AWIDTH-1]}}, a};
   assign b_ext = {{(SWIDTH-BWIDTH){b[BWIDTH-1]}}, b};
   assign sum   = a_ext + b_ext;

endmodule

// File: rtl/signed_adder_rr_sched.sv
// rtl/signed_adder_rr_sched.sv - round-robin time-sharing of one signed adder
module signed_adder_rr_sched
   import dsp_bb_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int AWIDTH = 16,
   parameter int BWIDTH = 16,
   localparam int SWIDTH = sum_width(AWIDTH, BWIDTH),
   localparam int CWIDTH = chan_width(NCH)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NCH-1:0]          i_valid,
   input  logic [NCH*AWIDTH-1:0]   i_a,
   input  logic [NCH*BWIDTH-1:0]   i_b,
   output logic [NCH-1:0]          o_ready,
   output logic                    o_valid,
   output logic [SWIDTH-1:0]       o_sum,
   output logic [CWIDTH-1:0]       o_chan,
   input  logic                    i_ready
);

   logic                     can_load;
   logic                     enable;
   logic                     transfer;
   logic [NCH-1:0]           grant;
   logic [CWIDTH-1:0]        gidx;
   logic signed [AWIDTH-1:0] a_sel;
   logic signed [BWIDTH-1:0] b_sel;
   logic signed [SWIDTH-1:0] sum;

   // Result register can take a new sum when empty or draining this cycle.
   assign can_load = !o_valid || i_ready;
   assign enable   = can_load && !i_reset;
   assign transfer = |(grant & i_valid);
   assign o_ready  = grant;

   rr_arbiter #(.N(NCH)) u_arb (
      .clk     (i_clk),
      .reset   (i_reset),
      .req     (i_valid),
      .enable  (enable),
      .advance (transfer),
      .grant   (grant),
      .index   (gidx)
   );

   assign a_sel = i_a[int'(gidx)*AWIDTH +: AWIDTH];
   assign b_sel = i_b[int'(gidx)*BWIDTH +: BWIDTH];

   signed_adder #(.AWIDTH(AWIDTH), .BWIDTH(BWIDTH)) u_add (
      .a   (a_sel),
      .b   (b_sel),
      .sum (sum)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_chan  <= '0;
      end else if (transfer) begin
         o_valid <= 1'b1;
         o_sum   <= sum;
         o_chan  <= gidx;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_signed_adder_rr_sched.sv
// tb/tb_signed_adder_rr_sched.sv - randomized and directed bench for the adder scheduler
module tb_signed_adder_rr_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  v;
   logic [63:0] a;
   logic [63:0] b;
   logic        rdy;
   logic [3:0]  o_rdy;
   logic        o_v;
   logic [17:0] o_s;
   logic [1:0]  o_c;

   logic        rst2;
   logic [3:0]  v2;
   logic [31:0] a2;
   logic [47:0] b2;
   logic        rdy2;
   logic [3:0]  o_rdy2;
   logic        o_v2;
   logic [13:0] o_s2;
   logic [1:0]  o_c2;

   int checks = 0;
   int errors = 0;

   bit          m_valid;
   logic [17:0] m_sum;
   int          m_chan;
   int          m_ptr;
   int          last_g;

   always #5 clk = ~clk;

   signed_adder_rr_sched #(.NCH(4), .AWIDTH(16), .BWIDTH(16)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_valid (v),
      .i_a     (a),
      .i_b     (b),
      .o_ready (o_rdy),
      .o_valid (o_v),
      .o_sum   (o_s),
      .o_chan  (o_c),
      .i_ready (rdy)
   );

   signed_adder_rr_sched #(.NCH(4), .AWIDTH(8), .BWIDTH(12)) dut2 (
      .i_clk   (clk),
      .i_reset (rst2),
      .i_valid (v2),
      .i_a     (a2),
      .i_b     (b2),
      .o_ready (o_rdy2),
      .o_valid (o_v2),
      .o_sum   (o_s2),
      .o_chan  (o_c2),
      .i_ready (rdy2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected winner this cycle, or -1 when nothing may be accepted.
   function automatic int exp_grant();
      int k;
      if (rst) return -1;
      if (m_valid && !rdy) return -1;
      for (int i = 0; i < 4; i++) begin
         k = (m_ptr + i) % 4;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic cycle();
      int g;
      int x;
      int y;
      logic [3:0] er;
      #1;
      g  = exp_grant();
      er = (g < 0) ? 4'b0000 : 4'(1 << g);
      check("ready", 64'(o_rdy), 64'(er));
      check("valid", 64'(o_v), 64'(m_valid));
      check("sum",   64'(o_s), 64'(m_sum));
      check("chan",  64'(o_c), 64'(m_chan));
      @(posedge clk);
      last_g = -1;
      if (rst) begin
         m_valid = 1'b0;
         m_sum   = '0;
         m_chan  = 0;
         m_ptr   = 0;
      end else if (g >= 0) begin
         x       = $signed(a[g*16 +: 16]);
         y       = $signed(b[g*16 +: 16]);
         m_sum   = 18'(x + y);
         m_chan  = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % 4;
         last_g  = g;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      m_valid = 1'b0;
      m_sum   = '0;
      m_chan  = 0;
      m_ptr   = 0;
      last_g  = -1;
      rst  = 1'b1; v  = 4'b1111; rdy  = 1'b1;
      a    = 64'h0004_0003_0002_0001;
      b    = 64'h0040_0030_0020_0010;
      rst2 = 1'b1; v2 = 4'b0000; rdy2 = 1'b1; a2 = '0; b2 = '0;
      @(negedge clk);

      // reset with every channel requesting
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      v = 4'b0000;

      // single channel, both extremes
      a[32 +: 16] = 16'sd32767; b[32 +: 16] = 16'sd32767; v = 4'b0100;
      cycle();
      v = 4'b0000;
      #1;
      check("max_sum",  64'(o_s), 64'(18'd65534));
      check("max_chan", 64'(o_c), 64'd2);
      cycle();
      a[32 +: 16] = 16'h8000; b[32 +: 16] = 16'h8000; v = 4'b0100;
      cycle();
      v = 4'b0000;
      #1;
      check("min_sum", 64'(o_s), 64'(18'h30000));
      cycle();

      // full contention, then stall, then sparse
      v = 4'b1111;
      for (int i = 0; i < 8; i++) cycle();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      v = 4'b1010;
      for (int i = 0; i < 6; i++) cycle();

      // mixed widths on the second instance, with reset during a stall
      rst2 = 1'b0;
      v2 = 4'b0001; a2[7:0] = 8'h80; b2[11:0] = 12'h7FF;
      #1;
      check("w_ready0", 64'(o_rdy2), 64'b0001);
      cycle();
      #1;
      check("w_valid", 64'(o_v2), 64'd1);
      check("w_sum",   64'(o_s2), 64'(14'd1919));
      check("w_chan",  64'(o_c2), 64'd0);
      rdy2 = 1'b0; v2 = 4'b0100;
      #1;
      check("w_stall_ready", 64'(o_rdy2), 64'd0);
      cycle();
      #1;
      check("w_stall_valid", 64'(o_v2), 64'd1);
      check("w_stall_sum",   64'(o_s2), 64'(14'd1919));
      rst2 = 1'b1;
      #1;
      check("w_rst_ready", 64'(o_rdy2), 64'd0);
      cycle();
      #1;
      check("w_rst_valid", 64'(o_v2), 64'd0);
      check("w_rst_sum",   64'(o_s2), 64'd0);
      rst2 = 1'b0; rdy2 = 1'b1; v2 = 4'b1111;
      #1;
      check("w_ptr_zero", 64'(o_rdy2), 64'b0001);
      cycle();
      #1;
      check("w_after_chan",  64'(o_c2), 64'd0);
      check("w_after_valid", 64'(o_v2), 64'd1);

      // random traffic; operands only change when the channel is free
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 4; k++) begin
            if (!v[k] || last_g == k) begin
               v[k] = 1'($urandom % 2);
               a[k*16 +: 16] = 16'($urandom);
               b[k*16 +: 16] = 16'($urandom);
            end
         end
         rdy = ($urandom % 4) != 0;
         rst = ($urandom % 64) == 0;
         cycle();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
